// File: rtl/app_reg_bank_if.sv
// fx bus bundle between the bus decoder (master) and a register bank slave.
// Byte-wide writes and reads with a registered one-cycle read response.
interface app_reg_bank_if;
    logic        fx_wr;
    logic [21:0] fx_waddr;
    logic [7:0]  fx_data;
    logic        fx_rd;
    logic [21:0] fx_raddr;
    logic [7:0]  fx_q;

    modport master (
        output fx_wr, fx_waddr, fx_data, fx_rd, fx_raddr,
        input  fx_q
    );

    modport slave (
        input  fx_wr, fx_waddr, fx_data, fx_rd, fx_raddr,
        output fx_q
    );
endinterface

// File: rtl/app_reg_bank.sv
// fx bus register bank: atomic 16-bit config registers, sticky W1C status with
// maskable irq, saturating event counter and tear-free 16-bit snapshot reads.
module app_reg_bank #(
    parameter int                    CFG_NUM  = 4,
    parameter logic [15:0]           CFG_BASE = 16'h0040,
    parameter logic [CFG_NUM*16-1:0] CFG_RST  = {CFG_NUM{16'h0003}},
    parameter int                    STU_W    = 8,
    parameter int                    CNT_W    = 16,
    parameter logic [7:0]            VERSION  = 8'h02
) (
    input  logic                    clk_sys,
    input  logic                    rst,
    input  logic [5:0]              dev_id,
    app_reg_bank_if.slave           fx,
    input  logic [STU_W-1:0]        stu_event,
    output logic [CFG_NUM*16-1:0]   cfg_out,
    output logic [CFG_NUM-1:0]      cfg_upd,
    output logic [STU_W-1:0]        stu_sticky,
    output logic                    irq
);

    localparam int               TAG_W   = $clog2(CFG_NUM + 1);
    localparam logic [TAG_W-1:0] TAG_CNT = TAG_W'(CFG_NUM);
    localparam logic [16:0]      CFG_END = 17'(CFG_BASE) + 17'(2 * CFG_NUM);

    logic [15:0]        cfg_r      [CFG_NUM];
    logic [7:0]         stage_lo_r [CFG_NUM];
    logic [CFG_NUM-1:0] pend_r;
    logic [CFG_NUM-1:0] cfg_upd_r;
    logic [STU_W-1:0]   sticky_r;
    logic [STU_W-1:0]   irq_mask_r;
    logic               irq_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [7:0]         shadow_r;
    logic [TAG_W-1:0]   tag_r;
    logic               tag_vld_r;
    logic [7:0]         fx_q_r;

    logic               wr_acc_s;
    logic               rd_acc_s;
    logic [15:0]        w_off_s;
    logic [15:0]        r_off_s;
    logic [5:0]         w_rel_s;
    logic [5:0]         r_rel_s;
    logic               w_cfg_s;
    logic               r_cfg_s;
    logic [CFG_NUM-1:0] w_sel_s;
    logic [CFG_NUM-1:0] r_sel_s;
    logic [15:0]        r_word_s;
    logic [15:0]        cnt16_s;
    logic [STU_W-1:0]   w1c_s;
    logic               mask_wr_s;
    logic               cnt_clr_s;
    logic               ev_any_s;
    logic               pair_s;
    logic               pair_hi_s;
    logic [15:0]        word_s;
    logic [TAG_W-1:0]   tag_sel_s;
    logic [7:0]         rd_plain_s;
    logic [7:0]         rd_data_s;
    logic               snap_ld_s;
    logic               snap_hit_s;

    // Address select and config-region decode for both bus directions.
    always_comb begin
        wr_acc_s = fx.fx_wr && (fx.fx_waddr[21:16] == dev_id);
        rd_acc_s = fx.fx_rd && (fx.fx_raddr[21:16] == dev_id);
        w_off_s  = fx.fx_waddr[15:0];
        r_off_s  = fx.fx_raddr[15:0];
        w_rel_s  = 6'(w_off_s - CFG_BASE);
        r_rel_s  = 6'(r_off_s - CFG_BASE);
        w_cfg_s  = ({1'b0, w_off_s} >= {1'b0, CFG_BASE}) && ({1'b0, w_off_s} < CFG_END);
        r_cfg_s  = ({1'b0, r_off_s} >= {1'b0, CFG_BASE}) && ({1'b0, r_off_s} < CFG_END);
        w_sel_s  = {CFG_NUM{1'b0}};
        r_sel_s  = {CFG_NUM{1'b0}};
        r_word_s = 16'h0000;
        for (int k = 0; k < CFG_NUM; k++) begin
            w_sel_s[k] = w_cfg_s && (w_rel_s[5:1] == 5'(k));
            r_sel_s[k] = r_cfg_s && (r_rel_s[5:1] == 5'(k));
            r_word_s   = r_word_s | (r_sel_s[k] ? cfg_r[k] : 16'h0000);
        end
    end

    // Control-register write strobes and the combined event flag.
    always_comb begin
        cnt16_s   = 16'(cnt_r);
        ev_any_s  = |stu_event;
        mask_wr_s = wr_acc_s && (w_off_s == 16'h0021);
        cnt_clr_s = wr_acc_s && (w_off_s == 16'h0030);
        if (wr_acc_s && (w_off_s == 16'h0020)) begin
            w1c_s = fx.fx_data[STU_W-1:0];
        end else begin
            w1c_s = {STU_W{1'b0}};
        end
    end

    // Read map; 16-bit pairs (cfg regs and counter) are resolved separately.
    always_comb begin
        pair_s     = 1'b0;
        pair_hi_s  = 1'b0;
        word_s     = 16'h0000;
        tag_sel_s  = {TAG_W{1'b0}};
        rd_plain_s = 8'h00;
        if (r_cfg_s) begin
            pair_s    = 1'b1;
            pair_hi_s = r_rel_s[0];
            word_s    = r_word_s;
            tag_sel_s = TAG_W'(r_rel_s[5:1]);
        end else begin
            case (r_off_s)
                16'h0000: rd_plain_s = {2'b00, dev_id};
                16'h0001: rd_plain_s = VERSION;
                16'h0010: rd_plain_s = 8'(sticky_r);
                16'h0011: rd_plain_s = 8'(stu_event);
                16'h0021: rd_plain_s = 8'(irq_mask_r);
                16'h0030: begin
                    pair_s    = 1'b1;
                    pair_hi_s = 1'b0;
                    word_s    = cnt16_s;
                    tag_sel_s = TAG_CNT;
                end
                16'h0031: begin
                    pair_s    = 1'b1;
                    pair_hi_s = 1'b1;
                    word_s    = cnt16_s;
                    tag_sel_s = TAG_CNT;
                end
                default: rd_plain_s = 8'h00;
            endcase
        end
    end

    // Snapshot: a low-byte read captures the high byte so the pair reads tear-free.
    always_comb begin
        rd_data_s  = rd_plain_s;
        snap_ld_s  = 1'b0;
        snap_hit_s = 1'b0;
        if (pair_s && !pair_hi_s) begin
            rd_data_s = word_s[7:0];
            snap_ld_s = rd_acc_s;
        end else if (pair_s && tag_vld_r && (tag_r == tag_sel_s)) begin
            rd_data_s  = shadow_r;
            snap_hit_s = rd_acc_s;
        end else if (pair_s) begin
            rd_data_s = word_s[15:8];
        end else begin
            rd_data_s = rd_plain_s;
        end
    end

    // Config registers: low byte is staged, high byte commits the pair atomically.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            for (int k = 0; k < CFG_NUM; k++) begin
                cfg_r[k]      <= CFG_RST[16*k +: 16];
                stage_lo_r[k] <= 8'h00;
            end
            pend_r    <= {CFG_NUM{1'b0}};
            cfg_upd_r <= {CFG_NUM{1'b0}};
        end else begin
            cfg_upd_r <= {CFG_NUM{1'b0}};
            for (int k = 0; k < CFG_NUM; k++) begin
                if (wr_acc_s && w_sel_s[k]) begin
                    if (!w_rel_s[0]) begin
                        stage_lo_r[k] <= fx.fx_data;
                        pend_r[k]     <= 1'b1;
                    end else begin
                        cfg_r[k]     <= {fx.fx_data, pend_r[k] ? stage_lo_r[k] : cfg_r[k][7:0]};
                        pend_r[k]    <= 1'b0;
                        cfg_upd_r[k] <= 1'b1;
                    end
                end
            end
        end
    end

    // Sticky status, interrupt mask and registered interrupt.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            sticky_r   <= {STU_W{1'b0}};
            irq_mask_r <= {STU_W{1'b0}};
            irq_r      <= 1'b0;
        end else begin
            sticky_r <= (sticky_r & ~w1c_s) | stu_event;
            irq_r    <= |(sticky_r & irq_mask_r);
            if (mask_wr_s) begin
                irq_mask_r <= fx.fx_data[STU_W-1:0];
            end
        end
    end

    // Saturating event counter; a clear coinciding with an event leaves 1.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_clr_s) begin
            cnt_r <= ev_any_s ? CNT_W'(1) : {CNT_W{1'b0}};
        end else if (ev_any_s && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Registered read data plus snapshot shadow/tag state.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            fx_q_r    <= 8'h00;
            shadow_r  <= 8'h00;
            tag_r     <= {TAG_W{1'b0}};
            tag_vld_r <= 1'b0;
        end else begin
            fx_q_r <= rd_acc_s ? rd_data_s : 8'h00;
            if (snap_ld_s) begin
                shadow_r  <= word_s[15:8];
                tag_r     <= tag_sel_s;
                tag_vld_r <= 1'b1;
            end else if (snap_hit_s) begin
                tag_vld_r <= 1'b0;
            end
        end
    end

    // Flatten committed config values onto the output bus.
    always_comb begin
        cfg_out = {CFG_NUM*16{1'b0}};
        for (int k = 0; k < CFG_NUM; k++) begin
            cfg_out[16*k +: 16] = cfg_r[k];
        end
    end

    assign cfg_upd    = cfg_upd_r;
    assign stu_sticky = sticky_r;
    assign irq        = irq_r;
    assign fx.fx_q    = fx_q_r;

endmodule

// File: tb/tb_app_reg_bank.sv
// Directed bench for app_reg_bank: a behavioural model tracks the register map
// and is compared with the DUT outputs every cycle, plus literal spot checks.
module tb_app_reg_bank;
    localparam int N    = 4;
    localparam int BASE = 16'h40;

    logic             clk_sys = 1'b0;
    logic             rst     = 1'b1;
    logic [5:0]       dev_id  = 6'h05;
    logic [7:0]       stu_event = 8'h00;
    logic [N*16-1:0]  cfg_out;
    logic [N-1:0]     cfg_upd;
    logic [7:0]       stu_sticky;
    logic             irq;

    app_reg_bank_if fx ();

    app_reg_bank dut (
        .clk_sys    (clk_sys),
        .rst        (rst),
        .dev_id     (dev_id),
        .fx         (fx.slave),
        .stu_event  (stu_event),
        .cfg_out    (cfg_out),
        .cfg_upd    (cfg_upd),
        .stu_sticky (stu_sticky),
        .irq        (irq)
    );

    always #5 clk_sys = ~clk_sys;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Model state: plain integers, tag remembered as the low-byte address.
    int m_cfg [N];
    int m_stage [N];
    bit m_pend [N];
    bit m_upd [N];
    int m_sticky, m_mask, m_cnt, m_q, m_shadow, m_tag;
    bit m_tvld, m_irq;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_lo(int off);
        return (off == 16'h30) || (off >= BASE && off < BASE + 2 * N && ((off - BASE) % 2) == 0);
    endfunction

    function automatic int word_at(int lo);
        return (lo == 16'h30) ? m_cnt : m_cfg[(lo - BASE) / 2];
    endfunction

    task automatic model_step();
        int roff, woff, d, q, w1c, k, old_st, old_mask;
        bit rok, wok, ev, clr;
        for (int i = 0; i < N; i++) m_upd[i] = 1'b0;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_cfg[i] = 3; m_stage[i] = 0; m_pend[i] = 1'b0;
            end
            m_sticky = 0; m_mask = 0; m_cnt = 0; m_q = 0;
            m_shadow = 0; m_tag = 0; m_tvld = 1'b0; m_irq = 1'b0;
            return;
        end
        rok  = fx.fx_rd && (fx.fx_raddr[21:16] == dev_id);
        wok  = fx.fx_wr && (fx.fx_waddr[21:16] == dev_id);
        roff = int'(fx.fx_raddr[15:0]);
        woff = int'(fx.fx_waddr[15:0]);
        d    = int'(fx.fx_data);
        ev   = (stu_event != 8'h00);
        q = 0;
        if (rok) begin
            if (is_lo(roff)) begin
                q = word_at(roff) % 256;
                m_shadow = word_at(roff) / 256;
                m_tag = roff;
                m_tvld = 1'b1;
            end else if (is_lo(roff - 1)) begin
                if (m_tvld && m_tag == roff - 1) begin
                    q = m_shadow;
                    m_tvld = 1'b0;
                end else begin
                    q = word_at(roff - 1) / 256;
                end
            end else begin
                case (roff)
                    0:       q = int'(dev_id);
                    1:       q = 2;
                    16'h10:  q = m_sticky;
                    16'h11:  q = int'(stu_event);
                    16'h21:  q = m_mask;
                    default: q = 0;
                endcase
            end
        end
        m_q = q;
        old_st = m_sticky;
        old_mask = m_mask;
        w1c = 0;
        clr = 1'b0;
        if (wok) begin
            if (woff >= BASE && woff < BASE + 2 * N) begin
                k = (woff - BASE) / 2;
                if (((woff - BASE) % 2) == 0) begin
                    m_stage[k] = d; m_pend[k] = 1'b1;
                end else begin
                    m_cfg[k] = d * 256 + (m_pend[k] ? m_stage[k] : m_cfg[k] % 256);
                    m_pend[k] = 1'b0; m_upd[k] = 1'b1;
                end
            end else if (woff == 16'h20) w1c = d;
            else if (woff == 16'h21) m_mask = d;
            else if (woff == 16'h30) clr = 1'b1;
        end
        m_irq = (old_st & old_mask) != 0;
        m_sticky = ((m_sticky & ~w1c) | int'(stu_event)) & 255;
        if (clr) m_cnt = ev ? 1 : 0;
        else if (ev && m_cnt < 65535) m_cnt++;
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
        model_step();
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        fx.fx_wr = 1'b1; fx.fx_waddr = {dev_id, a}; fx.fx_data = d;
        tick();
        fx.fx_wr = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, input logic [7:0] exp, input string name);
        fx.fx_rd = 1'b1; fx.fx_raddr = {dev_id, a};
        tick();
        fx.fx_rd = 1'b0;
        check(name, 64'(fx.fx_q), 64'(exp));
    endtask

    // Per-cycle comparison of every output against the model.
    initial begin
        logic [N*16-1:0] e_cfg;
        logic [N-1:0]    e_upd;
        forever begin
            @(negedge clk_sys);
            if (chk_en) begin
                for (int k = 0; k < N; k++) begin
                    e_cfg[16*k +: 16] = 16'(m_cfg[k]);
                    e_upd[k] = m_upd[k];
                end
                check("m_cfg_out", 64'(cfg_out), 64'(e_cfg));
                check("m_cfg_upd", 64'(cfg_upd), 64'(e_upd));
                check("m_sticky", 64'(stu_sticky), 64'(m_sticky));
                check("m_irq", 64'(irq), 64'(m_irq));
                check("m_fx_q", 64'(fx.fx_q), 64'(m_q));
            end
        end
    end

    initial begin
        fx.fx_wr = 1'b0; fx.fx_rd = 1'b0; fx.fx_data = 8'h00;
        fx.fx_waddr = 22'h0; fx.fx_raddr = 22'h0;
        // 1. reset and basic reads
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_cfg", 64'(cfg_out), 64'h0003_0003_0003_0003);
        check("rst_irq", 64'(irq), 64'h0);
        tick();
        rd(16'h0000, 8'h05, "rd_devid");
        rd(16'h0001, 8'h02, "rd_version");
        rd(16'h0040, 8'h03, "rd_cfg0_lo");
        rd(16'h0041, 8'h00, "rd_cfg0_hi");
        tick();
        check("idle_q", 64'(fx.fx_q), 64'h0);
        // 2. atomic config commit
        wr(16'h0040, 8'h34);
        check("stage_no_change", 64'(cfg_out[15:0]), 64'h0003);
        wr(16'h0041, 8'h12);
        check("commit", 64'(cfg_out[15:0]), 64'h1234);
        check("upd_pulse", 64'(cfg_upd), 64'h1);
        tick();
        check("upd_clear", 64'(cfg_upd), 64'h0);
        wr(16'h0041, 8'hAB);
        check("lone_hi", 64'(cfg_out[15:0]), 64'hAB34);
        // 3. foreign device id
        fx.fx_wr = 1'b1; fx.fx_waddr = {6'h06, 16'h0041}; fx.fx_data = 8'h77;
        fx.fx_rd = 1'b1; fx.fx_raddr = {6'h06, 16'h0000};
        tick();
        fx.fx_wr = 1'b0; fx.fx_rd = 1'b0;
        check("foreign_cfg", 64'(cfg_out[15:0]), 64'hAB34);
        check("foreign_upd", 64'(cfg_upd), 64'h0);
        check("foreign_q", 64'(fx.fx_q), 64'h0);
        // 4. sticky status and irq
        stu_event = 8'h05;
        tick();
        stu_event = 8'h00;
        wr(16'h0021, 8'h04);
        tick();
        check("sticky_set", 64'(stu_sticky), 64'h05);
        check("irq_on", 64'(irq), 64'h1);
        rd(16'h0010, 8'h05, "rd_sticky");
        rd(16'h0021, 8'h04, "rd_mask");
        stu_event = 8'h03;
        rd(16'h0011, 8'h03, "rd_raw_event");
        stu_event = 8'h04;
        wr(16'h0020, 8'h04);
        stu_event = 8'h00;
        check("set_wins", 64'(stu_sticky), 64'h07);
        wr(16'h0020, 8'h07);
        check("w1c", 64'(stu_sticky), 64'h00);
        check("irq_lag", 64'(irq), 64'h1);
        tick();
        check("irq_off", 64'(irq), 64'h0);
        // read and write of the same address in one cycle
        fx.fx_wr = 1'b1; fx.fx_waddr = {dev_id, 16'h0021}; fx.fx_data = 8'h0F;
        fx.fx_rd = 1'b1; fx.fx_raddr = {dev_id, 16'h0021};
        tick();
        fx.fx_wr = 1'b0; fx.fx_rd = 1'b0;
        check("rw_same_cycle", 64'(fx.fx_q), 64'h04);
        // cfg snapshot, interleaved pending, low-byte overwrite
        rd(16'h0040, 8'h34, "snap_cfg_lo");
        wr(16'h0041, 8'hCD);
        rd(16'h0041, 8'hAB, "snap_cfg_hi");
        rd(16'h0041, 8'hCD, "live_cfg_hi");
        wr(16'h0042, 8'h11);
        wr(16'h0044, 8'h22);
        wr(16'h0043, 8'h33);
        wr(16'h0045, 8'h44);
        check("interleave", 64'(cfg_out[47:16]), 64'h4422_3311);
        wr(16'h0046, 8'h01);
        wr(16'h0046, 8'h02);
        wr(16'h0047, 8'h03);
        check("lo_overwrite", 64'(cfg_out[63:48]), 64'h0302);
        rd(16'h0050, 8'h00, "rd_unmapped");
        // 5. counter
        wr(16'h0030, 8'h00);
        stu_event = 8'h01;
        for (int i = 0; i < 255; i++) tick();
        stu_event = 8'h00;
        rd(16'h0030, 8'hFF, "cnt_lo_ff");
        stu_event = 8'h01;
        tick();
        stu_event = 8'h00;
        rd(16'h0031, 8'h00, "cnt_snap_hi");
        rd(16'h0031, 8'h01, "cnt_live_hi");
        stu_event = 8'h02;
        for (int i = 0; i < 65539; i++) tick();
        stu_event = 8'h00;
        rd(16'h0030, 8'hFF, "cnt_sat_lo");
        rd(16'h0031, 8'hFF, "cnt_sat_hi");
        stu_event = 8'h01;
        wr(16'h0030, 8'h00);
        stu_event = 8'h00;
        rd(16'h0030, 8'h01, "cnt_clr_ev_lo");
        rd(16'h0031, 8'h00, "cnt_clr_ev_hi");
        // 6. reset between low and high byte
        wr(16'h0042, 8'h99);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_cfg", 64'(cfg_out[31:16]), 64'h0003);
        wr(16'h0043, 8'h55);
        check("after_rst_hi", 64'(cfg_out[31:16]), 64'h5503);
        tick();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/app_reg_bank.md
Name: app_reg_bank

Overview:
Parametrised register bank slave on the fx bus for application blocks. It provides CFG_NUM atomic 16-bit config registers and STU_W sticky status bits with write-1-to-clear and a maskable interrupt. It also holds a saturating event counter and a tear-free snapshot read path for 16-bit values. It sits between the fx bus decoder and app datapath blocks, and is selected by the device id in address bits [21:16].

Parameters:
CFG_NUM, 4, number of 16-bit config registers (1..32)
CFG_BASE, 16'h40, byte address of cfg reg 0 low byte; reg k low at CFG_BASE+2k, high at CFG_BASE+2k+1; must be >= 16'h40
CFG_RST, {4{16'h0003}}, flattened reset values, CFG_NUM*16 bits, reg k in bits [16k+15:16k]
STU_W, 8, status/event bit count (1..8)
CNT_W, 16, event counter width (9..16)
VERSION, 8'h02, read-only version byte

Ports:
clk_sys  in  1  system clock
rst  in  1  synchronous active-high reset
dev_id  in  6  device id, compared with addr[21:16]
fx_wr  in  1  write strobe, one byte per cycle
fx_waddr  in  22  write address
fx_data  in  8  write data
fx_rd  in  1  read strobe
fx_raddr  in  22  read address
fx_q  out  8  read data, registered
stu_event  in  STU_W  status set pulses, one bit per source
cfg_out  out  CFG_NUM*16  committed config values
cfg_upd  out  CFG_NUM  one-cycle pulse per reg on commit
stu_sticky  out  STU_W  sticky status
irq  out  1  registered interrupt

Behaviour:
- Interface: one clock, clk_sys. Reset rst is synchronous and active-high. All state is sampled on posedge clk_sys.
- Select: a write is accepted when fx_wr=1 and fx_waddr[21:16]==dev_id. A read is accepted when fx_rd=1 and fx_raddr[21:16]==dev_id. The byte offset is addr[15:0].
- Map:
  - 0x00 R: dev_id, zero-extended.
  - 0x01 R: VERSION.
  - 0x10 R: stu_sticky.
  - 0x11 R: raw stu_event of the read cycle.
  - 0x20 W: W1C mask.
  - 0x21 RW: irq_mask.
  - 0x30/0x31 R: counter low/high. Any write to 0x30 clears the counter.
  - CFG region RW.
  - Any other address reads 0; writes to it are ignored.
- Reset: cfg_out = CFG_RST. stage_lo, pend, stu_sticky, irq_mask, counter, shadow, shadow tag valid, fx_q, cfg_upd and irq are all 0.
- Cfg write, low byte: stage_lo[k] <= data and pend[k] <= 1. cfg_out does not change.
- Cfg write, high byte:
  - If pend[k]=1, cfg[k] <= {data, stage_lo[k]}.
  - If pend[k]=0, cfg[k] <= {data, cfg[k][7:0]}.
  - In both cases pend[k] <= 0.
  - cfg_upd[k] is 1 in the cycle the new value first appears on cfg_out, and 0 otherwise.
- A second low-byte write before the high byte overwrites stage_lo[k]. Pending state is per register, so interleaved writes to different regs do not interfere.
- Read latency: fx_q is valid the cycle after the accepted fx_rd. fx_q is 0 in any cycle following a non-accepted read.
- Snapshot:
  - Reading a 16-bit low byte (cfg k low or 0x30) returns the live low byte. In the same edge it loads shadow <= live high byte and tag <= that register.
  - Reading the matching high byte with the tag valid returns shadow and clears the tag.
  - Otherwise the high-byte read returns the live high byte.
  - Any other read leaves the tag unchanged.
- Read and write to the same address in the same cycle: the read returns the pre-write value.
- Sticky: stu_sticky <= (stu_sticky & ~w1c) | stu_event. When a set and a clear hit the same bit in the same cycle, the set wins. w1c is fx_data on a write to 0x20, else 0.
- irq <= |(stu_sticky & irq_mask), registered. It lags sticky by one cycle.
- Counter:
  - Increments by 1 in each cycle where |stu_event=1.
  - Saturates at all-ones.
  - A clear in the same cycle as an event gives 1.
  - Counter high bits beyond CNT_W read as 0.
- rst asserted mid-transaction aborts it: pending low bytes are discarded and the cfg values return to CFG_RST.

Test Plan:
1. Reset, then read 0x00, 0x01, 0x40, 0x41 with dev_id=6'h05 -> fx_q = 0x05, 0x02, 0x03, 0x00, each one cycle after its fx_rd; fx_q=0 in idle cycles.
2. Write 0x40=0x34, check cfg_out[15:0] still 0x0003; write 0x41=0x12 -> cfg_out[15:0]=0x1234 with cfg_upd[0]=1 for exactly one cycle. Then write 0x41=0xAB with no low byte pending -> 0xAB34.
3. Repeat a write with addr[21:16]=6'h06 while dev_id=6'h05 -> no change, no cfg_upd, fx_q=0.
4. Pulse stu_event=0x05, set irq_mask=0x04 -> stu_sticky=0x05, irq=1 the next cycle. Write 0x20=0x04 in the same cycle as stu_event=0x04 -> bit 2 stays 1. Write 0x20=0x05 alone -> sticky=0x00, irq=0 one cycle later.
5. Load counter to 0x00FF, read 0x30 (returns 0xFF); apply one event so the counter becomes 0x0100; read 0x31 -> returns 0x00 (snapshot), a second read of 0x31 returns 0x01. Drive 2^CNT_W+3 events -> counter reads 0xFFFF. Write 0x30 together with an event -> counter=1.
6. Assert rst between the low and high byte writes of cfg reg 1 -> cfg_out reg 1=0x0003; a following lone high-byte write 0x43=0x55 -> 0x5503.
